clk_div_monitor: RTL and testbench

- Receiving end of the divided-clock pulse stream produced by the team's clock dividers (e.g. the divide-by-3 one-hot pulse).
- Runs on the fast source clock and samples the synchronous divided pulse.
- Measures its period and high time, declares lock after consecutive matches against the expected ratio, and flags ratio errors and lost-pulse timeouts.
- Sits beside each divider as a built-in checker; its outputs feed status registers.

---
 rtl/clk_div_pkg.sv | 24 ++
 rtl/clk_div_edge_cnt.sv | 53 +++++
 rtl/clk_div_monitor.sv | 137 +++++++++++++
 tb/tb_clk_div_monitor.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared definitions for the divided-clock monitor: FSM encoding,
// default expected ratios for the dividers in the design, and helpers.
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    MEASURE = 2'b01,
    LOCKED  = 2'b10
  } state_e;

  // Expected period / high time pairs for each divider instance.
  localparam int unsigned DIV2_EXP = 2;
  localparam int unsigned DIV2_HI  = 1;
  localparam int unsigned DIV3_EXP = 3;
  localparam int unsigned DIV3_HI  = 1;
  localparam int unsigned DIV4_EXP = 4;
  localparam int unsigned DIV4_HI  = 2;

  // Increment that sticks at all-ones.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/clk_div_edge_cnt.sv
// Rising-edge detector plus saturating period and high-time counters
// for the sampled divided pulse.
module clk_div_edge_cnt
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             div_i,
  output logic             rise_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic [CNT_W-1:0] hcnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             div_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;

  assign rise_o = div_i & ~div_q;
  assign cnt_o  = cnt_q;
  assign hcnt_o = hcnt_q;

  // Next counter values: restart at 1 on a rise, otherwise count up and stick.
  always_comb begin
    cnt_d  = cnt_q;
    hcnt_d = hcnt_q;
    if (rise_o) begin
      cnt_d  = CNT_ONE;
      hcnt_d = CNT_ONE;
    end else begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
      if (div_i && (hcnt_q != CNT_MAX)) hcnt_d = hcnt_q + CNT_ONE;
    end
  end

  // Register the delayed pulse and both counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= 1'b0;
      cnt_q  <= '0;
      hcnt_q <= '0;
    end else begin
      div_q  <= div_i;
      cnt_q  <= cnt_d;
      hcnt_q <= hcnt_d;
    end
  end

endmodule

// File: rtl/clk_div_monitor.sv
// Built-in checker for a clock divider: measures period and high time of
// the divided pulse, declares lock after consecutive matches, and flags
// ratio errors and lost-pulse timeouts.
module clk_div_monitor
  import clk_div_pkg::*;
#(
  parameter int unsigned DIV_EXP  = 3,
  parameter int unsigned HI_EXP   = 1,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned LOCK_CNT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             div_i,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] high_o,
  output logic             valid_o,
  output logic             lock_o,
  output logic             err_o,
  output logic             timeout_o,
  output logic [7:0]       err_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] DIV_EXP_C  = CNT_W'(DIV_EXP);
  localparam logic [CNT_W-1:0] HI_EXP_C   = CNT_W'(HI_EXP);
  localparam logic [3:0]       LOCK_CNT_C = 4'(LOCK_CNT);

  logic             rise;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hcnt;

  clk_div_edge_cnt #(
    .CNT_W(CNT_W)
  ) u_edge_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .div_i  (div_i),
    .rise_o (rise),
    .cnt_o  (cnt),
    .hcnt_o (hcnt)
  );

  state_e           state_q;
  logic [3:0]       match_q;
  logic [CNT_W-1:0] period_q, high_q;
  logic             valid_q, lock_q, err_q, tmo_q;
  logic [7:0]       err_cnt_q;

  logic       hit;
  logic       sat;
  logic [3:0] match_inc;

  assign hit       = (cnt == DIV_EXP_C) && (hcnt == HI_EXP_C);
  // Rise wins over saturation in the same cycle.
  assign sat       = (cnt == CNT_MAX) && !rise;
  assign match_inc = match_q + 4'd1;

  assign period_o  = period_q;
  assign high_o    = high_q;
  assign valid_o   = valid_q;
  assign lock_o    = lock_q;
  assign err_o     = err_q;
  assign timeout_o = tmo_q;
  assign err_cnt_o = err_cnt_q;

  // Lock FSM with registered measurement and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      match_q   <= '0;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      lock_q    <= 1'b0;
      err_q     <= 1'b0;
      tmo_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rise) begin
            state_q <= MEASURE;
            match_q <= '0;
          end
        end
        MEASURE: begin
          if (rise) begin
            period_q <= cnt;
            high_q   <= hcnt;
            valid_q  <= 1'b1;
            if (hit) begin
              match_q <= match_inc;
              if (match_inc == LOCK_CNT_C) begin
                state_q <= LOCKED;
                lock_q  <= 1'b1;
              end
            end else begin
              match_q <= '0;
            end
          end else if (sat) begin
            tmo_q   <= 1'b1;
            lock_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        LOCKED: begin
          if (rise) begin
            period_q <= cnt;
            high_q   <= hcnt;
            valid_q  <= 1'b1;
            if (!hit) begin
              err_q     <= 1'b1;
              err_cnt_q <= sat_inc8(err_cnt_q);
              lock_q    <= 1'b0;
              match_q   <= '0;
              state_q   <= MEASURE;
            end
          end else if (sat) begin
            tmo_q   <= 1'b1;
            lock_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          lock_q  <= 1'b0;
          match_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_div_monitor.sv
// Bench for clk_div_monitor: directed scenarios with literal expectations
// plus randomized pulse trains, all compared every cycle against a
// timestamp-based reference model.
module tb_clk_div_monitor;

  localparam int DIV   = 3;
  localparam int HI    = 1;
  localparam int LOCKN = 4;
  localparam int MAXC  = 255;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       div_i = 1'b0;
  logic [7:0] period_o, high_o, err_cnt_o;
  logic       valid_o, lock_o, err_o, timeout_o;

  always #5 clk = ~clk;

  clk_div_monitor #(
    .DIV_EXP (DIV),
    .HI_EXP  (HI),
    .CNT_W   (8),
    .LOCK_CNT(LOCKN)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .div_i     (div_i),
    .period_o  (period_o),
    .high_o    (high_o),
    .valid_o   (valid_o),
    .lock_o    (lock_o),
    .err_o     (err_o),
    .timeout_o (timeout_o),
    .err_cnt_o (err_cnt_o)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: tracks the time of the last rising edge and the number
  // of high cycles since then; lock is a run-length of good periods.
  int now_c = 0, last_rise = 0, high_acc = 0, run = 0;
  bit prev = 0, have_ref = 0, locked = 0;
  int e_period = 0, e_high = 0, e_errcnt = 0;
  bit e_valid = 0, e_lock = 0, e_err = 0, e_tmo = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    prev = 0; have_ref = 0; locked = 0; run = 0; high_acc = 0;
    e_period = 0; e_high = 0; e_errcnt = 0;
    e_valid = 0; e_lock = 0; e_err = 0; e_tmo = 0;
  endtask

  task automatic model_step(input bit d);
    bit rise, good;
    int per, hi;
    rise = d && !prev;
    e_valid = 0; e_err = 0; e_tmo = 0;
    if (rise) begin
      if (have_ref) begin
        per = now_c - last_rise;
        if (per > MAXC) per = MAXC;
        hi = (high_acc > MAXC) ? MAXC : high_acc;
        e_period = per; e_high = hi; e_valid = 1;
        good = (per == DIV) && (hi == HI);
        if (locked) begin
          if (!good) begin
            e_err = 1;
            if (e_errcnt < 255) e_errcnt++;
            locked = 0; run = 0;
          end
        end else begin
          run = good ? run + 1 : 0;
          if (run >= LOCKN) locked = 1;
        end
      end else begin
        have_ref = 1; run = 0;
      end
      last_rise = now_c;
      high_acc = 1;
    end else begin
      if (d) high_acc++;
      if (have_ref && (now_c - last_rise) >= MAXC) begin
        e_tmo = 1; locked = 0; have_ref = 0;
      end
    end
    e_lock = locked;
    prev = d;
    now_c++;
  endtask

  // One clk cycle with div_i = d; returns shortly after the active edge.
  task automatic cyc(input bit d);
    @(negedge clk);
    div_i = d;
    if (!rst_n) model_reset();
    else model_step(d);
    @(posedge clk);
    #2;
  endtask

  task automatic pulse(input int p, input int h);
    for (int i = 0; i < p; i++) cyc(i < h);
  endtask

  task automatic release_rst();
    @(negedge clk);
    div_i = 1'b0;
    rst_n = 1'b1;
  endtask

  // Per-cycle comparison of every output against the model.
  always @(posedge clk) begin
    #1;
    chk("period", int'(period_o), e_period);
    chk("high", int'(high_o), e_high);
    chk("valid", int'(valid_o), int'(e_valid));
    chk("lock", int'(lock_o), int'(e_lock));
    chk("err", int'(err_o), int'(e_err));
    chk("timeout", int'(timeout_o), int'(e_tmo));
    chk("err_cnt", int'(err_cnt_o), e_errcnt);
  end

  initial begin
    int r, p, h, n;
    // Reset state
    for (int i = 0; i < 3; i++) cyc(1'b0);
    chk("rst_period", int'(period_o), 0);
    chk("rst_lock", int'(lock_o), 0);
    chk("rst_errcnt", int'(err_cnt_o), 0);
    release_rst();

    // Divide-by-3 train: first measurement and lock on the 5th rise
    pulse(3, 1);
    cyc(1'b1);
    chk("first_valid", int'(valid_o), 1);
    chk("first_period", int'(period_o), 3);
    chk("first_high", int'(high_o), 1);
    chk("first_nolock", int'(lock_o), 0);
    cyc(1'b0); cyc(1'b0);
    pulse(3, 1); pulse(3, 1);
    cyc(1'b1);
    chk("lock5", int'(lock_o), 1);
    chk("lock5_valid", int'(valid_o), 1);
    cyc(1'b0); cyc(1'b0);

    // Stretched period while locked
    pulse(4, 1);
    cyc(1'b1);
    chk("str_period", int'(period_o), 4);
    chk("str_err", int'(err_o), 1);
    chk("str_errcnt", int'(err_cnt_o), 1);
    chk("str_unlock", int'(lock_o), 0);
    cyc(1'b0);
    chk("str_err_1cyc", int'(err_o), 0);
    cyc(1'b0);
    pulse(3, 1); pulse(3, 1); pulse(3, 1);
    cyc(1'b1);
    chk("relock", int'(lock_o), 1);

    // Held low: timeout exactly when the count reaches 255
    for (int i = 0; i < 254; i++) cyc(1'b0);
    chk("tmo_early", int'(timeout_o), 0);
    cyc(1'b0);
    chk("tmo", int'(timeout_o), 1);
    chk("tmo_unlock", int'(lock_o), 0);
    cyc(1'b0);
    chk("tmo_1cyc", int'(timeout_o), 0);
    cyc(1'b1);
    chk("tmo_ref_novalid", int'(valid_o), 0);
    cyc(1'b0); cyc(1'b0);
    pulse(3, 1); pulse(3, 1); pulse(3, 1);
    cyc(1'b1);
    chk("tmo_relock", int'(lock_o), 1);
    cyc(1'b0); cyc(1'b0);

    // High time 2 while locked
    pulse(3, 2);
    cyc(1'b1);
    chk("hi2_high", int'(high_o), 2);
    chk("hi2_err", int'(err_o), 1);
    chk("hi2_unlock", int'(lock_o), 0);
    chk("hi2_errcnt", int'(err_cnt_o), 2);
    cyc(1'b0); cyc(1'b0);
    pulse(3, 1); pulse(3, 1);

    // Asynchronous reset mid-measurement (two matches accumulated)
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_period", int'(period_o), 0);
    chk("arst_high", int'(high_o), 0);
    chk("arst_errcnt", int'(err_cnt_o), 0);
    chk("arst_lock", int'(lock_o), 0);
    chk("arst_valid", int'(valid_o), 0);
    cyc(1'b0); cyc(1'b0);
    release_rst();
    pulse(3, 1); pulse(3, 1); pulse(3, 1);
    cyc(1'b1);
    chk("arst_nolock4", int'(lock_o), 0);
    chk("arst_valid4", int'(valid_o), 1);
    cyc(1'b0); cyc(1'b0);
    cyc(1'b1);
    chk("arst_lock5", int'(lock_o), 1);
    cyc(1'b0); cyc(1'b0);

    // 300 forced mismatches, relocking in between
    for (int k = 0; k < 300; k++) begin
      pulse(4, 1);
      for (int j = 0; j < 4; j++) pulse(3, 1);
    end
    cyc(1'b1);
    chk("sat_errcnt", int'(err_cnt_o), 255);
    chk("sat_lock", int'(lock_o), 1);
    cyc(1'b0); cyc(1'b0);

    // Randomized pulse trains, long lows and long highs
    for (int k = 0; k < 400; k++) begin
      r = $urandom_range(0, 99);
      if (r < 65) begin
        pulse(3, 1);
      end else if (r < 90) begin
        p = $urandom_range(2, 6);
        h = $urandom_range(1, p - 1);
        pulse(p, h);
      end else if (r < 95) begin
        n = $urandom_range(200, 300);
        for (int i = 0; i < n; i++) cyc(1'b0);
      end else begin
        n = $urandom_range(200, 280);
        for (int i = 0; i < n; i++) cyc(1'b1);
        cyc(1'b0);
      end
    end
    cyc(1'b0); cyc(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
